// File: rtl/alu_ctrl_seq_if.sv
// Opcode handshake and datapath-control bundle for alu_ctrl_seq.
// The requester drives the master side; the sequencer implements the slave side.
interface alu_ctrl_seq_if #(
  parameter int unsigned OP_W    = 3,
  parameter int unsigned SHAMT_W = 4
);
  logic               IN_VALID;
  logic               IN_READY;
  logic [OP_W-1:0]    OP;
  logic [SHAMT_W-1:0] SHAMT;
  logic               CISEL;
  logic               BISEL;
  logic               SHIFT_LA;
  logic               SHIFT_LR;
  logic               LOGICAL_OP;
  logic [1:0]         OSEL;
  logic               STEP;
  logic               LAST;
  logic               BUSY;
  logic               ILLEGAL;

  modport master (
    output IN_VALID, OP, SHAMT,
    input  IN_READY, CISEL, BISEL, SHIFT_LA, SHIFT_LR, LOGICAL_OP, OSEL,
           STEP, LAST, BUSY, ILLEGAL
  );

  modport slave (
    input  IN_VALID, OP, SHAMT,
    output IN_READY, CISEL, BISEL, SHIFT_LA, SHIFT_LR, LOGICAL_OP, OSEL,
           STEP, LAST, BUSY, ILLEGAL
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: turns accepted opcodes into per-cycle control words; shifts run one bit per STEP.
// Optional macro ALU_CTRL_ILLEGAL_TRAP_EN: illegal opcodes raise sticky ILLEGAL instead of executing as op0.
module alu_ctrl_seq #(
  parameter int unsigned OP_W    = 3,
  parameter int unsigned SHAMT_W = 4
) (
  input logic           CLK,
  input logic           RESET_N,
  alu_ctrl_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    SHIFT
  } state_t;

  typedef struct packed {
    logic       cisel;
    logic       bisel;
    logic       shift_la;
    logic       shift_lr;
    logic       logical_op;
    logic [1:0] osel;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    cisel:      1'b0,
    bisel:      1'b0,
    shift_la:   1'b0,
    shift_lr:   1'b1,
    logical_op: 1'b0,
    osel:       2'd0
  };

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t             state;
  logic [SHAMT_W-1:0] cnt;
  ctrl_t              ctrl_q;
  logic               step_q;
  logic               last_q;
  logic               busy_q;
  logic               illegal_q;

  ctrl_t              dec_ctrl;
  logic               dec_shift;
  logic               dec_illegal;
  logic               ready;
  logic               accept;

  assign ready  = (state == IDLE) || last_q;
  assign accept = bus.IN_VALID && ready;

  // Decode of the offered opcode; only captured into registers on acceptance.
  always_comb begin
    dec_ctrl    = CTRL_IDLE;
    dec_shift   = 1'b0;
    dec_illegal = 1'b0;
    case (bus.OP)
      OP_W'(0): dec_ctrl = CTRL_IDLE;
      OP_W'(1): begin
        dec_ctrl.cisel = 1'b1;
        dec_ctrl.bisel = 1'b1;
      end
      OP_W'(2): begin
        dec_ctrl.osel     = 2'd1;
        dec_ctrl.shift_la = 1'b1;
        dec_shift         = 1'b1;
      end
      OP_W'(3): begin
        dec_ctrl.osel = 2'd1;
        dec_shift     = 1'b1;
      end
      OP_W'(4): begin
        dec_ctrl.osel     = 2'd1;
        dec_ctrl.shift_lr = 1'b0;
        dec_shift         = 1'b1;
      end
      OP_W'(5): begin
        dec_ctrl.osel       = 2'd2;
        dec_ctrl.logical_op = 1'b1;
      end
      OP_W'(6): dec_ctrl.osel = 2'd2;
      default:  dec_illegal = 1'b1;
    endcase
    // A zero-length shift collapses to a single pass-through step.
    if (dec_shift && (bus.SHAMT == '0)) begin
      dec_ctrl      = CTRL_IDLE;
      dec_ctrl.osel = 2'd3;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= IDLE;
      cnt       <= '0;
      ctrl_q    <= CTRL_IDLE;
      step_q    <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept && TRAP_EN && dec_illegal) begin
      state     <= IDLE;
      cnt       <= '0;
      ctrl_q    <= CTRL_IDLE;
      step_q    <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b1;
    end else if (accept && dec_shift && (bus.SHAMT != '0)) begin
      state  <= SHIFT;
      cnt    <= bus.SHAMT - SHAMT_W'(1);
      ctrl_q <= dec_ctrl;
      step_q <= 1'b1;
      last_q <= (bus.SHAMT == SHAMT_W'(1));
      busy_q <= 1'b1;
    end else if (accept) begin
      state  <= EXEC;
      cnt    <= '0;
      ctrl_q <= dec_ctrl;
      step_q <= 1'b1;
      last_q <= 1'b1;
      busy_q <= 1'b1;
    end else if ((state == SHIFT) && (cnt != '0)) begin
      // Remaining shift bits reuse the control word captured at acceptance.
      cnt    <= cnt - SHAMT_W'(1);
      step_q <= 1'b1;
      last_q <= (cnt == SHAMT_W'(1));
      busy_q <= 1'b1;
    end else begin
      state  <= IDLE;
      cnt    <= '0;
      ctrl_q <= CTRL_IDLE;
      step_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
    end
  end

  assign bus.IN_READY   = ready;
  assign bus.CISEL      = ctrl_q.cisel;
  assign bus.BISEL      = ctrl_q.bisel;
  assign bus.SHIFT_LA   = ctrl_q.shift_la;
  assign bus.SHIFT_LR   = ctrl_q.shift_lr;
  assign bus.LOGICAL_OP = ctrl_q.logical_op;
  assign bus.OSEL       = ctrl_q.osel;
  assign bus.STEP       = step_q;
  assign bus.LAST       = last_q;
  assign bus.BUSY       = busy_q;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  assign bus.ILLEGAL    = illegal_q;
`else
  assign bus.ILLEGAL    = 1'b0;
`endif

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 SHALL have parameter OP_W, default 3, meaning opcode width (min 3).
REQ-002 SHALL have parameter SHAMT_W, default 4, meaning shift-amount width; max shift = 2^SHAMT_W-1.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RESET_N  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port IN_VALID  input  1  opcode offered.
REQ-006 SHALL have port IN_READY  output  1  opcode accepted when IN_VALID&IN_READY at a rising edge.
REQ-007 SHALL have port OP  input  OP_W  opcode.
REQ-008 SHALL have port SHAMT  input  SHAMT_W  shift amount (shift ops only).
REQ-009 SHALL have ports CISEL, BISEL, SHIFT_LA, SHIFT_LR, LOGICAL_OP  output  1 each  datapath controls.
REQ-010 SHALL have port OSEL  output  2  result mux select.
REQ-011 SHALL have port STEP  output  1  control word valid this cycle.
REQ-012 SHALL have port LAST  output  1  final STEP of current op.
REQ-013 SHALL have port BUSY  output  1  op in flight.
REQ-014 SHALL have port ILLEGAL  output  1  sticky illegal-opcode flag.

Function
REQ-015 All outputs except IN_READY SHALL be registered; IN_READY SHALL be decoded from registered state only (no IN_VALID path).
REQ-016 Decode per STEP: op0 OSEL=0; op1 CISEL=BISEL=1, OSEL=0; op2 OSEL=1, SHIFT_LA=1; op3 OSEL=1; op4 OSEL=1, SHIFT_LR=0; op5 OSEL=2, LOGICAL_OP=1; op6 OSEL=2; codes >=7 illegal.
REQ-017 When STEP=0, controls SHALL be CISEL=BISEL=SHIFT_LA=LOGICAL_OP=0, SHIFT_LR=1, OSEL=0, LAST=0.
REQ-018 States SHALL be IDLE, EXEC, SHIFT; BUSY=1 in EXEC/SHIFT.
REQ-019 IN_READY SHALL be 1 in IDLE and in any cycle with LAST=1, else 0.
REQ-020 Non-shift op accepted at edge N: EXEC, exactly one STEP with LAST=1 in cycle after N.
REQ-021 Shift op (2,3,4) with SHAMT=k>=1: SHIFT, k consecutive single-bit STEPs with identical controls, LAST=1 on k-th; counter loaded k-1, decrements per STEP.
REQ-022 Shift op with SHAMT=0: one STEP with OSEL=3 (pass-through), shift controls 0, SHIFT_LR=1, LAST=1.
REQ-023 Acceptance in a LAST cycle SHALL start the new op's first STEP on the next cycle (zero bubble); otherwise return to IDLE.
REQ-024 OP/SHAMT SHALL be latched at acceptance; later input changes SHALL not affect the op in flight.
REQ-025 IN_VALID while IN_READY=0 SHALL be ignored (not accepted, not queued).

Reset
REQ-026 RESET_N=0 at a rising edge SHALL force IDLE, counter 0, STEP=LAST=BUSY=0, ILLEGAL=0, controls per REQ-017, IN_READY=1 after the edge.
REQ-027 Reset mid-operation SHALL discard the in-flight op; no further STEP for it.
REQ-028 IN_VALID during reset SHALL not be accepted.

Configuration
REQ-029 Macro ALU_CTRL_ILLEGAL_TRAP_EN defined: illegal opcode SHALL be accepted, produce no STEP, set ILLEGAL on next edge (held until reset), leave state IDLE.
REQ-030 Macro ALU_CTRL_ILLEGAL_TRAP_EN undefined: ILLEGAL SHALL be constant 0; illegal opcode SHALL execute as op0 (one STEP, OSEL=0).

Verification
REQ-031 OP=1 accepted at N -> cycle N+1: STEP=LAST=1, CISEL=BISEL=1, OSEL=0; N+2: IDLE, STEP=0.
REQ-032 OP=4, SHAMT=5 -> 5 STEPs, OSEL=1, SHIFT_LR=0; LAST only on 5th; IN_READY=0 on STEPs 1-4.
REQ-033 OP=2 SHAMT=3 then OP=5 held valid -> OP=5 accepted in LAST cycle; its STEP (OSEL=2, LOGICAL_OP=1) immediately follows, no gap.
REQ-034 OP=3, SHAMT=0 -> single STEP, OSEL=3, LAST=1.
REQ-035 OP=4, SHAMT=15, RESET_N=0 after 2nd STEP -> next cycle STEP=0, BUSY=0, IN_READY=1.
REQ-036 OP=7: with macro -> no STEP, ILLEGAL=1 persistent until reset; without -> one STEP OSEL=0, ILLEGAL=0.
